// File: rtl/parking_pkg.sv
// Shared command encoding, FSM state type and blocked-pattern lookup for the parking sensor blocks.
package parking_pkg;

  typedef enum logic [1:0] {
    CMD_ENTER       = 2'b00,
    CMD_EXIT        = 2'b01,
    CMD_ENTER_ABORT = 2'b10,
    CMD_EXIT_ABORT  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Blocked beams {a,b} (1 = blocked). cmd[0] selects the direction: 0 = A first, 1 = B first.
  function automatic logic [1:0] blocked_pattern(input state_e st, input cmd_e c);
    logic b_first;
    logic [1:0] pat;
    b_first = c[0];
    case (st)
      ST_PH1:  pat = b_first ? 2'b01 : 2'b10;
      ST_PH2:  pat = 2'b11;
      ST_PH3:  pat = b_first ? 2'b10 : 2'b01;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sensor_pattern_gen_phase_timer.sv
// Loadable down-counter; expire_c flags the last cycle of a loaded interval and the count stops at zero.
module phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         expire_c
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire_c = (count == W'(1));

endmodule

// File: rtl/sensor_pattern_gen.sv
// Emulates the two active-low beam sensors of a parking gate for ENTER/EXIT and their aborted variants.
module sensor_pattern_gen
  import parking_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] cmd,
  output logic       req_ready,
  output logic       sensor_a,
  output logic       sensor_b,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic [TW-1:0]   tmr_count;
  logic            tmr_expire;
  logic [1:0]      blk_d;
  logic            busy_d, done_d, ready_d;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .expire_c (tmr_expire)
  );

  // Next state, timer control and next-cycle output values.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = ST_PH1;
          cmd_d    = cmd_e'(cmd);
          tmr_load = 1'b1;
        end
      end
      ST_PH1: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (cmd_q[1]) begin
            state_d = ST_GAP;
            tmr_val = GAP_LD;
          end else begin
            state_d = ST_PH2;
          end
        end
      end
      ST_PH2: begin
        if (tmr_expire) begin
          state_d  = ST_PH3;
          tmr_load = 1'b1;
        end
      end
      ST_PH3: begin
        if (tmr_expire) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    blk_d   = blocked_pattern(state_d, cmd_d);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
    // The coming GAP cycle is the last one when the count it will hold is 1.
    done_d  = (state_d == ST_GAP) &&
              (tmr_load ? (GAP_CYCLES == 32'd1) : (32'(tmr_count) == 32'd2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_ENTER;
      sensor_a  <= 1'b1;
      sensor_b  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      sensor_a  <= ~blk_d[1];
      sensor_b  <= ~blk_d[0];
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Bench for sensor_pattern_gen: per-cycle expected waveform queue built from the command rules.
module tb_sensor_pattern_gen;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam logic [4:0] IDLE_V = 5'b11001; // {sensor_a, sensor_b, busy, done, req_ready}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       req_ready, sensor_a, sensor_b, busy, done;

  int errors = 0;
  int checks = 0;
  int dones  = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  sensor_pattern_gen #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .cmd       (cmd),
    .req_ready (req_ready),
    .sensor_a  (sensor_a),
    .sensor_b  (sensor_b),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [4:0] obs();
    return {sensor_a, sensor_b, busy, done, req_ready};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Expected waveform of one accepted command, one entry per cycle after acceptance.
  task automatic push_seq(input logic [1:0] c);
    logic [1:0] pat [3];
    int nph;
    if (c[0] == 1'b0) pat = '{2'b10, 2'b11, 2'b01};
    else              pat = '{2'b01, 2'b11, 2'b10};
    nph = c[1] ? 1 : 3;
    for (int p = 0; p < nph; p++)
      for (int k = 0; k < HOLD; k++)
        exp_q.push_back({~pat[p], 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < GAP; k++)
      exp_q.push_back({2'b11, 1'b1, (k == GAP - 1), 1'b0});
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic v, input logic [1:0] c, input string tag);
    logic [4:0] e;
    logic was_idle;
    req_valid = v;
    cmd       = c;
    @(negedge clk);
    was_idle = (exp_q.size() == 0);
    e = was_idle ? IDLE_V : exp_q[0];
    check(tag, obs(), e);
    if (done) dones++;
    if (!was_idle) void'(exp_q.pop_front());
    else if (v) push_seq(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, tag);
  endtask

  initial begin
    // Power-on reset
    #2 reset = 1'b0;
    #1 check("reset_async", obs(), IDLE_V);
    @(negedge clk);
    check("reset_hold", obs(), IDLE_V);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    idle_steps(2, "idle_after_reset");

    // Full and aborted commands
    step(1'b1, 2'b00, "enter_accept");
    idle_steps(3 * HOLD + GAP + 1, "enter");
    step(1'b1, 2'b01, "exit_accept");
    idle_steps(3 * HOLD + GAP + 1, "exit");
    step(1'b1, 2'b10, "enter_abort_accept");
    idle_steps(HOLD + GAP + 1, "enter_abort");
    step(1'b1, 2'b11, "exit_abort_accept");
    idle_steps(HOLD + GAP + 1, "exit_abort");

    // Command held valid and changing while busy
    dones = 0;
    step(1'b1, 2'b00, "jitter_accept");
    for (int i = 0; i < 3 * HOLD + GAP - 1; i++)
      step(1'b1, 2'($urandom_range(0, 3)), "jitter_busy");
    step(1'b0, 2'b00, "jitter_last");
    check_int("jitter_done_count", dones, 1);
    idle_steps(2, "jitter_idle");

    // Reset in the middle of PH2
    dones = 0;
    step(1'b1, 2'b00, "rst_mid_accept");
    idle_steps(HOLD + 2, "rst_mid_run");
    #2 reset = 1'b0;
    #1 check("rst_mid_async", obs(), IDLE_V);
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_hold", obs(), IDLE_V);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    idle_steps(3 * HOLD + GAP, "rst_mid_after");
    check_int("rst_mid_no_done", dones, 0);

    // ENTER then EXIT back to back
    step(1'b1, 2'b00, "b2b_enter");
    idle_steps(3 * HOLD + GAP, "b2b_enter_run");
    step(1'b1, 2'b01, "b2b_exit");
    idle_steps(3 * HOLD + GAP + 1, "b2b_exit_run");

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), "random");
    idle_steps(3 * HOLD + GAP + 2, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
